// File: rtl/strobe_capture_fifo.sv
// Strobe-qualified sample capture FIFO with sticky overflow flag.
// Optional saturating drop counter enabled by STROBE_CAPTURE_DROP_COUNT_EN.
module strobe_capture_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_en,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef STROBE_CAPTURE_DROP_COUNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              full, empty, do_rd, do_wr, drop;

  always_comb begin
    full  = (level_q == LW'(DEPTH));
    empty = (level_q == '0);
    do_rd = !empty && out_ready;
    // A full FIFO still accepts a strobe when the head retires on the same edge.
    do_wr = in_en && (!full || do_rd);
    drop  = in_en && !do_wr;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never cleared; the output mux hides stale contents while empty.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign level     = level_q;
  assign overflow  = overflow_q;

`ifdef STROBE_CAPTURE_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_strobe_capture_fifo.sv
// Self-checking bench for strobe_capture_fifo: queue model compared every cycle,
// plus directed literal expectations. Drop-count checks under STROBE_CAPTURE_DROP_COUNT_EN.
module tb_strobe_capture_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_en = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [$clog2(DEPTH):0] level;
  logic              overflow;
`ifdef STROBE_CAPTURE_DROP_COUNT_EN
  logic [7:0]        drop_cnt;
`endif

  strobe_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow)
`ifdef STROBE_CAPTURE_DROP_COUNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: contents in strobe order, sticky flag, saturating drop tally.
  int unsigned m_q[$];
  bit          m_ovf;
  int          m_drops;
  bit          chk_en = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input int unsigned d, input bit rdy);
    bit rd, wr;
    if (r) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      rd = (m_q.size() != 0) && rdy;
      wr = e && ((m_q.size() < DEPTH) || rd);
      if (rd) void'(m_q.pop_front());
      if (wr) m_q.push_back(d);
      if (e && !wr) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle 1 time unit.
  task automatic step(input bit r, input bit e, input logic [7:0] d, input bit rdy);
    rst       = r;
    in_en     = e;
    in_data   = e ? d : 8'hEE;  // garbage while not strobed
    out_ready = rdy;
    @(posedge clk);
    model_edge(r, e, int'(e ? d : 8'hEE), rdy);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("level",     int'(level),     m_q.size());
      check("out_valid", int'(out_valid), int'(m_q.size() != 0));
      check("out_data",  int'(out_data),  (m_q.size() != 0) ? int'(m_q[0]) : 0);
      check("overflow",  int'(overflow),  int'(m_ovf));
`ifdef STROBE_CAPTURE_DROP_COUNT_EN
      check("drop_cnt",  int'(drop_cnt),  m_drops);
`endif
    end
  end

  logic [7:0] pulse_vals [4];

  initial begin
    pulse_vals[0] = 8'h9A; pulse_vals[1] = 8'h2E;
    pulse_vals[2] = 8'h00; pulse_vals[3] = 8'h7F;

    step(1, 1, 8'h11, 1);
    chk_en = 1'b1;
    step(1, 0, 8'h00, 0);
    check("rst_level",     int'(level), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data",  int'(out_data), 0);
    check("rst_overflow",  int'(overflow), 0);

    // Sparse strobes with a ready sink: one-cycle latency, level never above 1.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, pulse_vals[i], 1);
      check("pulse_valid", int'(out_valid), 1);
      check("pulse_data",  int'(out_data), int'(pulse_vals[i]));
      check("pulse_level", int'(level), 1);
      for (int k = 0; k < 11; k++) begin
        step(0, 0, 8'h00, 1);
        check("pulse_idle_level_le1", int'(level <= 1), 1);
      end
    end

    // Six strobes into a stalled FIFO: two drops.
    for (int i = 1; i <= 6; i++) step(0, 1, 8'(i), 0);
    check("ovf_level", int'(level), 4);
    check("ovf_flag",  int'(overflow), 1);
`ifdef STROBE_CAPTURE_DROP_COUNT_EN
    check("ovf_drop_cnt", int'(drop_cnt), 2);
`endif
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", int'(out_data), i);
      step(0, 0, 8'h00, 1);
    end
    check("drain_empty", int'(out_valid), 0);

    // Full FIFO: strobe plus read on the same edge.
    for (int i = 0; i < 4; i++) step(0, 1, 8'h10 + 8'(i), 0);
    step(0, 1, 8'hAA, 1);
    check("full_rw_level", int'(level), 4);
    check("full_rw_head",  int'(out_data), 8'h11);
    check("full_rw_ovf",   int'(overflow), 1);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);

    // Interleaved writes and reads across the pointer wrap.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 8'h30 + 8'(i), i >= 2);
    check("wrap_level", int'(level), 2);
    check("wrap_head0", int'(out_data), 8'h38);
    step(0, 0, 8'h00, 1);
    check("wrap_head1", int'(out_data), 8'h39);
    step(0, 0, 8'h00, 1);
    check("wrap_empty", int'(out_valid), 0);

    // Mid-operation reset with level 3, overflow set, strobe and ready asserted.
    for (int i = 0; i < 5; i++) step(0, 1, 8'h60 + 8'(i), 0);
    step(0, 0, 8'h00, 1);
    check("pre_rst_level", int'(level), 3);
    step(1, 1, 8'h77, 1);
    check("mid_rst_level",     int'(level), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_overflow",  int'(overflow), 0);
    check("mid_rst_out_data",  int'(out_data), 0);
    step(0, 1, 8'h55, 0);
    check("first_wr_level", int'(level), 1);
    check("first_wr_data",  int'(out_data), 8'h55);

    // Long overflow run: counter saturates.
    for (int i = 0; i < 3; i++) step(0, 1, 8'h40 + 8'(i), 0);
    for (int i = 0; i < 301; i++) step(0, 1, 8'(i), 0);
    check("sat_overflow", int'(overflow), 1);
    check("sat_head",     int'(out_data), 8'h55);
`ifdef STROBE_CAPTURE_DROP_COUNT_EN
    check("sat_drop_cnt", int'(drop_cnt), 255);
`endif
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
